// File: rtl/srff_bank_multimode.sv
// Bank of WIDTH clocked flip-flops with a runtime-selectable SR/JK/D/T personality,
// sticky illegal-SR flags and a saturating state-change counter.
module srff_bank_multimode #(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      CNT_W     = 8,
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    parameter bit               SR11_HOLD = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic [WIDTH-1:0] err,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic [1:0]       MODE_SR = 2'b00;
    localparam logic [1:0]       MODE_JK = 2'b01;
    localparam logic [1:0]       MODE_D  = 2'b10;
    localparam logic [1:0]       MODE_T  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] nq_q, nq_d;
    logic [WIDTH-1:0] err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_next, jk_next;

    // Next-state selection for the whole bank, plus flag and counter updates
    always_comb begin
        sr_next = (q_q | (a & ~b)) & ~(~a & b);
        if (!SR11_HOLD) begin
            sr_next = sr_next & ~(a & b);
        end
        jk_next = (a & ~q_q) | (~b & q_q);

        q_d = q_q;
        if (en) begin
            unique case (mode)
                MODE_SR: q_d = sr_next;
                MODE_JK: q_d = jk_next;
                MODE_D:  q_d = a;
                MODE_T:  q_d = q_q ^ a;
                default: q_d = q_q;
            endcase
        end
        nq_d = ~q_d;

        // Set takes priority over a same-edge clear
        err_d = err_clr ? '0 : err_q;
        if (en && (mode == MODE_SR)) begin
            err_d = err_d | (a & b);
        end

        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (en && (q_d != q_q) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // nq resets to the complement so nq == ~q holds through reset too
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= RST_VAL;
            nq_q  <= ~RST_VAL;
            err_q <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            nq_q  <= nq_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign q       = q_q;
    assign nq      = nq_q;
    assign err     = err_q;
    assign chg_cnt = cnt_q;

endmodule
